port_uart_tx: RTL
=================

PORT_UART_TX -- requirements
Module: port_uart_tx

Interface
REQ-001 Parameter: DIVISOR, default 16, clock cycles per serial bit (legal range 2..1023).
REQ-002 Parameter: FIFO_DEPTH, default 8, byte entries in the transmit FIFO (power of two, 2..16).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 out_p0  input  8  data byte, driven from processor output port 0.
REQ-006 out_p1  input  8  command, driven from processor output port 1: bit7 = request toggle, bit0 = flush, other bits ignored.
REQ-007 in_p0  output  8  status to processor input port 0: bit7 = ack toggle, bits6:3 = FIFO count, bit2 = tx_busy, bit1 = empty, bit0 = full.
REQ-008 in_p1  output  8  transmitted-frame counter to processor input port 1.
REQ-009 tx  output  1  serial line; idles high.

Function
REQ-010 A request SHALL be pending whenever out_p1[7] differs from the registered ack bit.
REQ-011 A pending request SHALL be accepted on the first rising edge where the FIFO is not full and flush is low.
  - Acceptance writes out_p0 into the FIFO.
  - Acceptance sets ack equal to out_p1[7], so ack is visible on in_p0[7] one cycle after the accepting edge.
REQ-012 A request made while the FIFO is full SHALL stay pending without loss and SHALL be accepted once space frees.
  - Full is taken from the registered count.
  - A same-cycle pop SHALL NOT permit a push when the FIFO is full.
REQ-013 A simultaneous push and pop SHALL leave the count unchanged and preserve FIFO order.
REQ-014 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
  - Count SHALL range 0..FIFO_DEPTH.
  - in_p0[6:3] SHALL report the count, saturated to 15.
REQ-015 While flush (out_p1[0]) is high:
  - FIFO SHALL be emptied.
  - No request SHALL be accepted.
  - A frame in progress SHALL complete normally.
REQ-016 Transmit FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte and enter START.
  - tx SHALL fall low exactly 2 cycles after the acceptance edge when the FSM was idle and the FIFO empty.
REQ-018 Each bit SHALL last exactly DIVISOR cycles, counted by a bit timer that reloads on every state or bit change.
REQ-019 DATA SHALL shift 8 bits, LSB first; the bit index increments 0..7, then the FSM moves to PARITY or STOP per REQ-026.
REQ-020 STOP SHALL drive tx high for one bit time, then:
  - increment in_p1 modulo 256;
  - go to START directly if the FIFO is non-empty, with no idle gap;
  - otherwise go to IDLE.
REQ-021 tx_busy SHALL be high in every state except IDLE.
REQ-022 All outputs SHALL be registered or decoded from registers only, with no combinational path from out_p0 or out_p1 to any output.

Reset
REQ-023 While reset is high, the block SHALL immediately force:
  - tx = 1;
  - FSM = IDLE;
  - FIFO pointers and count = 0;
  - ack = 0;
  - in_p1 = 0;
  - bit timer and bit index = 0.
REQ-024 After reset, in_p0 SHALL read 8'b0000_0010 (empty only).
REQ-025 Reset asserted mid-frame SHALL abort the frame.
  - tx SHALL return high with no glitch low.
  - The aborted frame SHALL NOT be counted.
  - A request pending at release SHALL be accepted per REQ-011.

Configuration
REQ-026 Macro PORT_UART_TX_PARITY_EN controls the PARITY state.
  - Defined: PARITY is entered after data bit 7 and sends even parity (XOR of the 8 data bits) for one bit time; frame = 11 bits.
  - Undefined: PARITY is never entered; frame = 10 bits (start, 8 data, stop).

Verification
REQ-027 The bench SHALL cover these directed scenarios (DIVISOR=4, FIFO_DEPTH=8, macro undefined unless stated):
  - Reset, then out_p0=8'hA5 and toggle out_p1[7] 0->1: in_p0[7]=1 next cycle; tx low 2 cycles after acceptance; line reads 0,1,0,1,0,0,1,0,1,1 at 4 cycles/bit; in_p1=1 afterwards.
  - Nine toggles with no gap while tx is held busy: first 8 bytes accepted, count reaches 8, full=1; 9th stays pending (ack unchanged) and is accepted on the cycle after the first pop.
  - Three bytes 8'h01, 8'h02, 8'h03 queued: back-to-back frames with no idle gap; tx_busy stays high for 120 cycles; in_p1=3.
  - Flush high for 1 cycle with 4 bytes queued mid-frame: current frame completes; count=0; in_p1 increments by exactly 1.
  - Reset during DATA bit 3: tx=1 immediately; in_p0=8'h02; in_p1 unchanged from before reset.
  - PORT_UART_TX_PARITY_EN defined, byte 8'h07: parity bit=1; frame is 44 cycles long.

Source files
------------

// File: rtl/port_uart_tx.sv
// rtl/port_uart_tx.sv - port-mapped UART transmitter with byte FIFO and frame counter
// Optional even-parity bit after data bit 7: define PORT_UART_TX_PARITY_EN.
module port_uart_tx #(
  parameter int DIVISOR    = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] out_p0,
  input  logic [7:0] out_p1,
  output logic [7:0] in_p0,
  output logic [7:0] in_p1,
  output logic       tx
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(DIVISOR);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    frame_cnt;
  logic          tx_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ack;
  logic          flush, full, empty, push, pop, bit_end, frame_done;
  logic [4:0]    count_ext;
  logic [3:0]    count_sat;
  logic          unused_cmd_bits;

  assign flush           = out_p1[0];
  assign unused_cmd_bits = ^out_p1[6:1];
  assign full            = (count == CW'(FIFO_DEPTH));
  assign empty           = (count == '0);
  // Full comes from the registered count, so a pop in the same cycle never frees room for a push.
  assign push            = (out_p1[7] != ack) && !full && !flush;
  assign bit_end         = (timer == TW'(DIVISOR - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= out_p0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ack    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        ack    <= out_p1[7];
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_comb begin
    state_d    = state;
    timer_d    = bit_end ? '0 : timer + TW'(1);
    bit_idx_d  = bit_idx;
    data_d     = data_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        timer_d = '0;
        if (!empty && !flush) begin
          pop     = 1'b1;
          data_d  = mem[rd_ptr];
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef PORT_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          frame_done = 1'b1;
          // Chain straight into the next start bit so queued bytes go out with no idle gap.
          if (!empty && !flush) begin
            pop     = 1'b1;
            data_d  = mem[rd_ptr];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[bit_idx];
      PARITY:  tx_d = ^data_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      data_q    <= '0;
      frame_cnt <= '0;
      tx        <= 1'b1;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      bit_idx <= bit_idx_d;
      data_q  <= data_d;
      tx      <= tx_d;
      if (frame_done) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign count_ext = 5'(count);
  assign count_sat = (count_ext > 5'd15) ? 4'hF : count_ext[3:0];
  assign in_p0     = {ack, count_sat, (state != IDLE), empty, full};
  assign in_p1     = frame_cnt;

endmodule
